// File: rtl/uart_sim_pkg.sv
// Shared types and constants for the simulation-side UART input responder.
package uart_sim_pkg;

    typedef logic [7:0] uart_ch_t;

    // Character the DUT sees when nothing is available to hand over.
    localparam uart_ch_t UART_NO_DATA = 8'hff;

    typedef enum logic {
        READY = 1'b0,
        GAP   = 1'b1
    } resp_state_e;

endpackage

// File: rtl/uart_char_fifo.sv
// Character FIFO feeding the UART input responder: circular storage,
// read/write pointers wrapping modulo DEPTH, and an occupancy count.
// The head entry is presented combinationally; the owner only pops when
// count is non-zero. Reset is synchronous and active-low.
module uart_char_fifo
    import uart_sim_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_valid,
    input  uart_ch_t                 push_ch,
    output logic                     push_ready,
    input  logic                     pop,
    output uart_ch_t                 head_ch,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    uart_ch_t             mem_q [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 push_fire;
    logic                 pop_fire;

    // Acceptance depends only on registered occupancy, so a full FIFO refuses
    // a push even when a pop happens in the same cycle.
    always_comb begin
        push_ready = reset && (count_q != CNT_W'(DEPTH));
        push_fire  = push_valid && push_ready;
        pop_fire   = pop && (count_q != '0);
        head_ch    = mem_q[rd_ptr_q];
        count      = count_q;
    end

    // Pointer and count update; simultaneous push and pop leaves count unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({push_fire, pop_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers, cleared by reset so old contents are discarded.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clock) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= push_ch;
        end
    end

endmodule

// File: rtl/uart_in_responder.sv
// Simulation-side responder for the DUT's UART input channel. Answers each
// read request in the same cycle from a bench-filled character FIFO, or with
// 8'hff when no character is available or a pacing gap is running.
// Note: a bench-pushed 8'hff is indistinguishable from "no data" to the DUT.
// Optional macro UART_IN_ECHO_EN adds registered echo_valid/echo_ch outputs
// that report each delivered character one cycle later.
module uart_in_responder
    import uart_sim_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_valid,
    input  logic [7:0]               push_ch,
    output logic                     push_ready,
    input  logic                     io_uart_in_valid,
    output logic [7:0]               io_uart_in_ch,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         n_delivered,
    output logic [CNT_W-1:0]         n_empty_reads,
    output logic                     gap_active
`ifdef UART_IN_ECHO_EN
    ,
    output logic                     echo_valid,
    output logic [7:0]               echo_ch
`endif
);

    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    resp_state_e          state_q, state_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]     n_delivered_q, n_delivered_d;
    logic [CNT_W-1:0]     n_empty_reads_q, n_empty_reads_d;
    uart_ch_t             fifo_head;
    logic                 has_data;
    logic                 pop;
    logic                 empty_read;

    uart_char_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ch    (push_ch),
        .push_ready (push_ready),
        .pop        (pop),
        .head_ch    (fifo_head),
        .count      (fifo_count)
    );

    // Same-cycle response: the head is offered only while READY with data, and
    // nothing is delivered while reset is held.
    always_comb begin
        has_data      = (fifo_count != '0);
        pop           = reset && io_uart_in_valid && (state_q == READY) && has_data;
        empty_read    = reset && io_uart_in_valid && !pop;
        io_uart_in_ch = (reset && (state_q == READY) && has_data) ? fifo_head : UART_NO_DATA;
        gap_active    = (state_q == GAP);
        n_delivered   = n_delivered_q;
        n_empty_reads = n_empty_reads_q;
    end

    // Next state, gap countdown and saturating statistics counters.
    always_comb begin
        state_d         = state_q;
        gap_cnt_d       = gap_cnt_q;
        n_delivered_d   = n_delivered_q;
        n_empty_reads_d = n_empty_reads_q;
        case (state_q)
            READY: begin
                if (pop && (GAP_CYCLES > 0)) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = READY;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: state_d = READY;
        endcase
        if (pop && (n_delivered_q != '1)) begin
            n_delivered_d = n_delivered_q + CNT_W'(1);
        end
        if (empty_read && (n_empty_reads_q != '1)) begin
            n_empty_reads_d = n_empty_reads_q + CNT_W'(1);
        end
    end

    // Responder state register; reset returns to READY with cleared statistics.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= READY;
            gap_cnt_q       <= '0;
            n_delivered_q   <= '0;
            n_empty_reads_q <= '0;
        end else begin
            state_q         <= state_d;
            gap_cnt_q       <= gap_cnt_d;
            n_delivered_q   <= n_delivered_d;
            n_empty_reads_q <= n_empty_reads_d;
        end
    end

`ifdef UART_IN_ECHO_EN
    logic       echo_valid_q, echo_valid_d;
    uart_ch_t   echo_ch_q, echo_ch_d;

    // Echo the delivered character one cycle after it was handed to the DUT.
    always_comb begin
        echo_valid_d = pop;
        echo_ch_d    = pop ? fifo_head : echo_ch_q;
        echo_valid   = echo_valid_q;
        echo_ch      = echo_ch_q;
    end

    // Echo registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            echo_valid_q <= 1'b0;
            echo_ch_q    <= 8'h00;
        end else begin
            echo_valid_q <= echo_valid_d;
            echo_ch_q    <= echo_ch_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_in_responder.sv
// Self-checking bench for uart_in_responder. Two instances share the clock:
// dut_a uses the default pacing gap, dut_b has no gap and narrow counters so
// saturation is reachable. A scoreboard queue holds accepted characters.
module tb_uart_in_responder;

    localparam int DEPTH = 16;
    localparam int GAP_A = 4;
    localparam int CW_B  = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sel = 1'b0;
    logic push_valid = 1'b0;
    logic [7:0] push_ch = 8'h00;
    logic req = 1'b0;

    logic a_push_ready, a_gap, b_push_ready, b_gap;
    logic [7:0] a_ch, b_ch;
    logic [4:0] a_count, b_count;
    logic [31:0] a_ndel, a_nempty;
    logic [CW_B-1:0] b_ndel, b_nempty;
`ifdef UART_IN_ECHO_EN
    logic a_echo_v, b_echo_v;
    logic [7:0] a_echo_ch, b_echo_ch;
`endif

    always #5 clock = ~clock;

    uart_in_responder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_A), .CNT_W(32)) dut_a (
        .clock(clock), .reset(reset),
        .push_valid(push_valid && !sel), .push_ch(push_ch), .push_ready(a_push_ready),
        .io_uart_in_valid(req && !sel), .io_uart_in_ch(a_ch), .fifo_count(a_count),
        .n_delivered(a_ndel), .n_empty_reads(a_nempty), .gap_active(a_gap)
`ifdef UART_IN_ECHO_EN
        , .echo_valid(a_echo_v), .echo_ch(a_echo_ch)
`endif
    );

    uart_in_responder #(.DEPTH(DEPTH), .GAP_CYCLES(0), .CNT_W(CW_B)) dut_b (
        .clock(clock), .reset(reset),
        .push_valid(push_valid && sel), .push_ch(push_ch), .push_ready(b_push_ready),
        .io_uart_in_valid(req && sel), .io_uart_in_ch(b_ch), .fifo_count(b_count),
        .n_delivered(b_ndel), .n_empty_reads(b_nempty), .gap_active(b_gap)
`ifdef UART_IN_ECHO_EN
        , .echo_valid(b_echo_v), .echo_ch(b_echo_ch)
`endif
    );

    wire [7:0]  obs_ch     = sel ? b_ch : a_ch;
    wire        obs_ready  = sel ? b_push_ready : a_push_ready;
    wire        obs_gap    = sel ? b_gap : a_gap;
    wire [4:0]  obs_count  = sel ? b_count : a_count;
    wire [31:0] obs_del    = sel ? {29'd0, b_ndel} : a_ndel;
    wire [31:0] obs_empty  = sel ? {29'd0, b_nempty} : a_nempty;
`ifdef UART_IN_ECHO_EN
    wire        obs_echo_v  = sel ? b_echo_v : a_echo_v;
    wire [7:0]  obs_echo_ch = sel ? b_echo_ch : a_echo_ch;
`endif

    logic [7:0] sb[$];
    int m_del, m_empty, m_gap_cnt;
    bit m_in_gap, m_echo_v;
    logic [7:0] m_echo_ch;
    logic [7:0] e_ch, s_ch, e_echo_ch, s_echo_ch;
    bit e_ready, s_ready, e_gap, s_gap, e_echo_v, s_echo_v;
    int checks = 0;
    int failures = 0;

    task automatic model_reset();
        sb.delete();
        m_del = 0; m_empty = 0; m_gap_cnt = 0;
        m_in_gap = 0; m_echo_v = 0; m_echo_ch = 8'h00;
    endtask

    // Reference model: computes this cycle's expectations, then advances.
    task automatic model_cycle(input bit pv, input logic [7:0] pc, input bit rq);
        bit deliver;
        int gc, cap;
        gc  = sel ? 0 : GAP_A;
        cap = sel ? 7 : 32'h7fffffff;
        e_ready   = sb.size() < DEPTH;
        e_gap     = m_in_gap;
        e_echo_v  = m_echo_v;
        e_echo_ch = m_echo_ch;
        e_ch      = (!m_in_gap && sb.size() > 0) ? sb[0] : 8'hff;
        deliver   = rq && !m_in_gap && sb.size() > 0;
        m_echo_v  = deliver;
        if (deliver) m_echo_ch = sb[0];
        if (m_in_gap) begin
            if (rq && m_empty < cap) m_empty++;
            if (m_gap_cnt == 0) m_in_gap = 0;
            else m_gap_cnt--;
        end else if (deliver) begin
            void'(sb.pop_front());
            if (m_del < cap) m_del++;
            if (gc > 0) begin
                m_in_gap = 1;
                m_gap_cnt = gc - 1;
            end
        end else if (rq && m_empty < cap) begin
            m_empty++;
        end
        if (pv && e_ready) sb.push_back(pc);
    endtask

    task automatic applyStimulus(input bit pv, input logic [7:0] pc, input bit rq);
        model_cycle(pv, pc, rq);
        push_valid = pv; push_ch = pc; req = rq;
        #3;
        s_ch = obs_ch; s_ready = obs_ready; s_gap = obs_gap;
`ifdef UART_IN_ECHO_EN
        s_echo_v = obs_echo_v; s_echo_ch = obs_echo_ch;
`else
        s_echo_v = e_echo_v; s_echo_ch = e_echo_ch;
`endif
        @(posedge clock); #1;
        push_valid = 1'b0; req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0; push_valid = 1'b0; req = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++; if (a_push_ready !== 1'b0 || b_push_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready_low: got a=%b b=%b expected 0", a_push_ready, b_push_ready); end
        checks++; if (a_ch !== 8'hff || b_ch !== 8'hff) begin failures++; $display("[TB] FAIL reset_ch: got a=%h b=%h expected ff", a_ch, b_ch); end
        do_reset();
        #3;
        checks++; if (a_push_ready !== 1'b1 || b_push_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_high: got a=%b b=%b expected 1", a_push_ready, b_push_ready); end
        checks++; if (a_count !== 5'd0 || b_count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count: got a=%0d b=%0d expected 0", a_count, b_count); end
        checks++; if (a_ndel !== 32'd0 || a_nempty !== 32'd0 || b_ndel !== 3'd0 || b_nempty !== 3'd0) begin failures++; $display("[TB] FAIL reset_counters: got %0d %0d %0d %0d expected 0", a_ndel, a_nempty, b_ndel, b_nempty); end
        checks++; if (a_gap !== 1'b0 || a_ch !== 8'hff) begin failures++; $display("[TB] FAIL reset_gap_ch: got gap=%b ch=%h expected 0 ff", a_gap, a_ch); end
`ifdef UART_IN_ECHO_EN
        checks++; if (a_echo_v !== 1'b0 || a_echo_ch !== 8'h00) begin failures++; $display("[TB] FAIL reset_echo: got %b %h expected 0 00", a_echo_v, a_echo_ch); end
`endif
        @(posedge clock); #1;
    endtask

    task automatic test_empty_read();
        sel = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
            checks++; if (s_ch !== e_ch) begin failures++; $display("[TB] FAIL empty_read_ch[%0d]: got %h expected %h", i, s_ch, e_ch); end
        end
        checks++; if (obs_empty !== 32'd3) begin failures++; $display("[TB] FAIL empty_read_count: got %0d expected 3", obs_empty); end
        checks++; if (obs_del !== 32'd0) begin failures++; $display("[TB] FAIL empty_read_delivered: got %0d expected 0", obs_del); end
    endtask

    task automatic test_ordered();
        logic [7:0] chars [3];
        chars = '{8'h41, 8'h42, 8'h43};
        sel = 1'b1;
        do_reset();
        foreach (chars[i]) begin
            applyStimulus(1'b1, chars[i], 1'b0);
            checks++; if (s_ready !== e_ready) begin failures++; $display("[TB] FAIL ordered_ready[%0d]: got %b expected %b", i, s_ready, e_ready); end
        end
        checks++; if (obs_count !== 5'd3) begin failures++; $display("[TB] FAIL ordered_fill: got %0d expected 3", obs_count); end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, i < 3);
            if (i < 3) begin
                checks++; if (s_ch !== chars[i]) begin failures++; $display("[TB] FAIL ordered_ch[%0d]: got %h expected %h", i, s_ch, chars[i]); end
            end
            checks++; if (obs_count !== 5'(sb.size())) begin failures++; $display("[TB] FAIL ordered_count[%0d]: got %0d expected %0d", i, obs_count, sb.size()); end
            checks++; if (s_echo_v !== e_echo_v || (e_echo_v && s_echo_ch !== e_echo_ch)) begin failures++; $display("[TB] FAIL ordered_echo[%0d]: got %b/%h expected %b/%h", i, s_echo_v, s_echo_ch, e_echo_v, e_echo_ch); end
        end
        checks++; if (obs_del !== 32'd3) begin failures++; $display("[TB] FAIL ordered_delivered: got %0d expected 3", obs_del); end
    endtask

    task automatic test_pacing();
        logic [7:0] exp_seq [6];
        int echo_pulses;
        exp_seq = '{8'h61, 8'hff, 8'hff, 8'hff, 8'hff, 8'h62};
        echo_pulses = 0;
        sel = 1'b0;
        do_reset();
        applyStimulus(1'b1, 8'h61, 1'b0);
        applyStimulus(1'b1, 8'h62, 1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 8'h00, i < 6);
            if (s_echo_v) echo_pulses++;
            if (i < 6) begin
                checks++; if (s_ch !== exp_seq[i] || s_ch !== e_ch) begin failures++; $display("[TB] FAIL pacing_ch[%0d]: got %h expected %h", i, s_ch, exp_seq[i]); end
                checks++; if (s_gap !== e_gap) begin failures++; $display("[TB] FAIL pacing_gap[%0d]: got %b expected %b", i, s_gap, e_gap); end
            end
            if (i == 5) begin
                checks++; if (obs_empty !== 32'd4) begin failures++; $display("[TB] FAIL pacing_empty: got %0d expected 4", obs_empty); end
            end
        end
        checks++; if (obs_del !== 32'd2) begin failures++; $display("[TB] FAIL pacing_delivered: got %0d expected 2", obs_del); end
`ifdef UART_IN_ECHO_EN
        checks++; if (echo_pulses != 2) begin failures++; $display("[TB] FAIL pacing_echo_pulses: got %0d expected 2", echo_pulses); end
`endif
    endtask

    task automatic test_full_boundary();
        int next_idx;
        bit pv, rq;
        logic [7:0] pc;
        next_idx = 0;
        sel = 1'b1;
        do_reset();
        for (int cyc = 0; cyc < 80; cyc++) begin
            pv = next_idx < 20;
            rq = cyc >= 17;
            pc = 8'h70 + 8'(next_idx * 4);
            applyStimulus(pv, pc, rq);
            if (pv && e_ready) next_idx++;
            checks++; if (s_ready !== e_ready) begin failures++; $display("[TB] FAIL full_ready[%0d]: got %b expected %b", cyc, s_ready, e_ready); end
            checks++; if (s_ch !== e_ch) begin failures++; $display("[TB] FAIL full_ch[%0d]: got %h expected %h", cyc, s_ch, e_ch); end
            checks++; if (obs_count !== 5'(sb.size())) begin failures++; $display("[TB] FAIL full_count[%0d]: got %0d expected %0d", cyc, obs_count, sb.size()); end
            if (cyc == 16) begin
                checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_drop: got %b expected 0", s_ready); end
            end
            if (cyc >= 17 && next_idx == 20 && sb.size() == 0) break;
        end
        checks++; if (next_idx != 20 || sb.size() != 0) begin failures++; $display("[TB] FAIL full_drain: got pushed=%0d left=%0d expected 20 0", next_idx, sb.size()); end
        checks++; if (obs_del !== 32'd7) begin failures++; $display("[TB] FAIL full_saturate: got %0d expected 7", obs_del); end
    endtask

    task automatic test_push_on_empty();
        sel = 1'b1;
        do_reset();
        applyStimulus(1'b1, 8'h5a, 1'b1);
        checks++; if (s_ch !== 8'hff) begin failures++; $display("[TB] FAIL poe_ch: got %h expected ff", s_ch); end
        checks++; if (obs_empty !== 32'd1 || obs_count !== 5'd1) begin failures++; $display("[TB] FAIL poe_counts: got empty=%0d count=%0d expected 1 1", obs_empty, obs_count); end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checks++; if (s_ch !== 8'h5a) begin failures++; $display("[TB] FAIL poe_next: got %h expected 5a", s_ch); end
        checks++; if (obs_del !== 32'd1) begin failures++; $display("[TB] FAIL poe_delivered: got %0d expected 1", obs_del); end
    endtask

    task automatic test_reset_mid_stream();
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'h80 + 8'(i), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checks++; if (s_ch !== 8'h80 || obs_count !== 5'd5) begin failures++; $display("[TB] FAIL mid_pre: got ch=%h count=%0d expected 80 5", s_ch, obs_count); end
        reset = 1'b0; req = 1'b1;
        #3;
        checks++; if (b_push_ready !== 1'b0 || b_ch !== 8'hff) begin failures++; $display("[TB] FAIL mid_during: got ready=%b ch=%h expected 0 ff", b_push_ready, b_ch); end
        @(posedge clock); #1;
        reset = 1'b1; req = 1'b0;
        model_reset();
        checks++; if (obs_count !== 5'd0 || obs_del !== 32'd0 || obs_empty !== 32'd0) begin failures++; $display("[TB] FAIL mid_cleared: got %0d %0d %0d expected 0 0 0", obs_count, obs_del, obs_empty); end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checks++; if (s_ch !== 8'hff || s_echo_v !== 1'b0) begin failures++; $display("[TB] FAIL mid_after: got ch=%h echo=%b expected ff 0", s_ch, s_echo_v); end
        checks++; if (obs_empty !== 32'd1) begin failures++; $display("[TB] FAIL mid_empty: got %0d expected 1", obs_empty); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_empty_read();
        test_ordered();
        test_pacing();
        test_full_boundary();
        test_push_on_empty();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_in_responder.md
Name: uart_in_responder

Overview:
- Simulation-side responder for the DUT's UART input channel.
- The DUT raises io_uart_in_valid to request one character. This block answers in the same cycle on io_uart_in_ch, using a character FIFO filled by the bench (DPI/stdin feeder).
- When no character is available, or during the pacing gap, it answers 8'hff ("no data").
- Instantiated in the simulation top in place of the constant 8'hff tie-off.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- GAP_CYCLES, 4, idle cycles forced after each delivered character (0 = back-to-back delivery allowed).
- CNT_W, 32, width of the statistics counters.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-low reset
- push_valid  in  1  bench offers a character
- push_ch  in  8  offered character
- push_ready  out  1  FIFO can accept; a push occurs when push_valid && push_ready
- io_uart_in_valid  in  1  DUT read request, one character per asserted cycle
- io_uart_in_ch  out  8  response character, combinational
- fifo_count  out  $clog2(DEPTH)+1  current occupancy
- n_delivered  out  CNT_W  characters handed to the DUT
- n_empty_reads  out  CNT_W  requests answered with 8'hff
- gap_active  out  1  high while in state GAP

Behaviour:
- Reset: taken when reset==0 at a clock edge. Clears pointers, count and counters, and forces state READY.
  - Outputs during/after reset: push_ready=0 while reset==0, then 1; fifo_count=0; n_delivered=0; n_empty_reads=0; gap_active=0; io_uart_in_ch=8'hff.
  - Reset mid-operation discards all FIFO contents, with no delivery in that cycle.
- FIFO: circular buffer with rd_ptr/wr_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a count register.
  - push_ready = (count != DEPTH) && reset; registered state only, so there is no combinational path from io_uart_in_valid.
  - Full with push_valid asserted: push is not accepted, even if a pop occurs in the same cycle.
  - Empty with a push and a read in the same cycle: no bypass. The read returns 8'hff and counts as an empty read; the pushed character is readable next cycle.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
- Response path:
  - State READY and count>0: io_uart_in_ch = mem[rd_ptr].
  - Otherwise: io_uart_in_ch = 8'hff.
  - The output is valid regardless of io_uart_in_valid, and the DUT samples it in the same cycle.
- State machine (2 states):
  - READY: a request with count>0 pops the head and increments n_delivered. If GAP_CYCLES>0 the state moves to GAP and gap_cnt is loaded with GAP_CYCLES-1. A request with count==0 increments n_empty_reads and the state stays READY.
  - GAP: gap_active=1. Any request is answered 8'hff, increments n_empty_reads and does not pop. gap_cnt decrements each cycle; when gap_cnt==0 the next state is READY.
  - With GAP_CYCLES==0 the GAP state is unreachable.
- Counters saturate at all-ones and do not wrap.
- A character value with bit 7 set (0x80..0xfe) is passed through unmodified. 8'hff pushed by the bench is indistinguishable from "no data" to the DUT; this is documented, not trapped.

Optional Feature:
- Macro UART_IN_ECHO_EN adds output ports echo_valid (1) and echo_ch (8).
  - One cycle after each delivered character: echo_valid=1 and echo_ch = the delivered character, both registered. Reset value is 0/8'h00.
  - The bench uses this to print input characters interleaved with DUT output.
- Without the macro, these ports and registers do not exist, and there is no other behavioural change.

Decomposition:
- Shared package uart_sim_pkg holds:
  - UART_NO_DATA = 8'hff
  - typedef uart_ch_t (logic [7:0])
  - typedef enum resp_state_e {READY, GAP}
- One natural sub-module: uart_char_fifo (storage, pointers, count, push_ready, head output). The responder FSM and counters stay in the top module.

Test Plan:
- Empty read: hold io_uart_in_valid=1 for 3 cycles with no pushes -> io_uart_in_ch=8'hff each cycle, n_empty_reads=3, n_delivered=0.
- Ordered delivery (GAP_CYCLES=0): push "A","B","C" (0x41,0x42,0x43), then request 3 consecutive cycles -> responses 0x41, 0x42, 0x43; fifo_count 3→0; n_delivered=3.
- Pacing (GAP_CYCLES=4): push 0x61,0x62 and request every cycle -> 0x61, then four cycles of 8'hff with gap_active=1, then 0x62; n_empty_reads=4.
- Full boundary (DEPTH=16): push 17 characters back-to-back -> push_ready drops after the 16th, the 17th is held off until one read, and wrap-around order is preserved across 20 total characters.
- Same-cycle push-on-empty plus read -> response 8'hff, n_empty_reads=1; the next-cycle read returns the pushed character.
- Reset mid-stream: with 5 characters queued, pull reset low for 1 cycle -> fifo_count=0, counters 0, next request returns 8'hff. With UART_IN_ECHO_EN, echo_valid pulses exactly once per delivered character.
